// File: rtl/expmul_pipe_pkg.sv
// Shared fixed-point types, default sizes and resize helper for the expmul pipeline.
package expmul_pipe_pkg;

    localparam int unsigned MAX_EMBEDDING_DIM = 4;
    localparam int unsigned MAX_SEQ_LENGTH    = 4;
    localparam int unsigned DEF_VEC_I         = 9;
    localparam int unsigned DEF_VEC_F         = 17;
    localparam int unsigned DEF_LW            = 5;
    localparam int unsigned LANE_W            = DEF_VEC_I + DEF_VEC_F;
    localparam int unsigned VEC_W             = (MAX_EMBEDDING_DIM + 1) * LANE_W;

    typedef logic signed [7:0]        q4_4_t;
    typedef logic signed [8:0]        q5_4_t;
    typedef logic signed [9:0]        q6_4_t;
    typedef logic signed [LANE_W-1:0] lane_t;
    typedef logic        [VEC_W-1:0]  vec_t;

    // Sign-extending widen from Q5.4 to Q6.4 (same fraction, one more integer bit).
    function automatic q6_4_t q_convert(input q5_4_t v);
        return {v[8], v};
    endfunction

endpackage

// File: rtl/expmul_pipe_if.sv
// Upstream/downstream handshake bundle for expmul_pipe.
interface expmul_pipe_if
    import expmul_pipe_pkg::*;
#(
    parameter int unsigned DIM     = MAX_EMBEDDING_DIM,
    parameter int unsigned VEC_I   = DEF_VEC_I,
    parameter int unsigned VEC_F   = DEF_VEC_F,
    parameter int unsigned SEQ_LEN = MAX_SEQ_LENGTH
) ();
    localparam int unsigned VBITS = (DIM + 1) * (VEC_I + VEC_F);
    localparam int unsigned KW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic             vld_in;
    logic             rdy_out;
    q4_4_t            a_in;
    q4_4_t            b_in;
    logic [VBITS-1:0] v_in;
    logic             bypass;
    logic             vld_out;
    logic             rdy_in;
    logic [VBITS-1:0] v_out;
    logic [KW-1:0]    kv_counter;
    logic             tile_last;
    logic             pos_clamp;

    modport master (
        output vld_in, a_in, b_in, v_in, bypass, rdy_in,
        input  rdy_out, vld_out, v_out, kv_counter, tile_last, pos_clamp
    );

    modport slave (
        input  vld_in, a_in, b_in, v_in, bypass, rdy_in,
        output rdy_out, vld_out, v_out, kv_counter, tile_last, pos_clamp
    );
endinterface

// File: rtl/expmul_lane_shift.sv
// One-lane arithmetic right barrel shifter (floor semantics), shift stages 2^(LW-1)..1.
module expmul_lane_shift #(
    parameter int unsigned W  = 26,
    parameter int unsigned LW = 5
) (
    input  logic [W-1:0]  lane_i,
    input  logic [LW-1:0] shamt_i,
    output logic [W-1:0]  lane_o
);
    logic signed [W-1:0] acc;

    // Apply the largest stage first; shifts past W saturate to the sign fill.
    always_comb begin
        acc = lane_i;
        for (int unsigned k = LW; k > 0; k--) begin
            if (shamt_i[k-1]) acc = acc >>> (1 << (k - 1));
        end
        lane_o = acc;
    end
endmodule

// File: rtl/expmul_pipe.sv
// Three-stage exp(a-b) scaling pipeline: v_out = v_in >>> L with L ~ -(a-b)*log2(e).
module expmul_pipe
    import expmul_pipe_pkg::*;
#(
    parameter int unsigned DIM     = MAX_EMBEDDING_DIM,
    parameter int unsigned VEC_I   = DEF_VEC_I,
    parameter int unsigned VEC_F   = DEF_VEC_F,
    parameter int unsigned SEQ_LEN = MAX_SEQ_LENGTH,
    parameter int unsigned LW      = DEF_LW
) (
    input  logic         clk,
    input  logic         rst,
    expmul_pipe_if.slave bus
);
    localparam int unsigned LANE_BITS = VEC_I + VEC_F;
    localparam int unsigned NLANES    = DIM + 1;
    localparam int unsigned VBITS     = NLANES * LANE_BITS;
    localparam int unsigned KW        = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int unsigned LMAX      = (1 << LW) - 1;

    logic             s1_v_q, s1_byp_q;
    q4_4_t            s1_a_q, s1_b_q;
    logic [VBITS-1:0] s1_lanes_q;
    logic             s2_v_q, s2_byp_q, s2_pos_q;
    logic [LW-1:0]    s2_l_q;
    logic [VBITS-1:0] s2_lanes_q;
    logic             s3_v_q, s3_pos_q;
    logic [VBITS-1:0] s3_lanes_q;
    logic [KW-1:0]    kv_q;

    logic             s1_ld, s2_ld, s3_ld;
    q5_4_t            x;
    q6_4_t            xw, t;
    logic signed [10:0] n;
    logic [6:0]       lr;
    logic [LW-1:0]    l_d;
    logic             pos_d;
    logic [LW-1:0]    shamt;
    logic [VBITS-1:0] shifted;

    assign s3_ld = !s3_v_q || bus.rdy_in;
    assign s2_ld = !s2_v_q || s3_ld;
    assign s1_ld = !s1_v_q || s2_ld;

    assign bus.rdy_out    = s1_ld;
    assign bus.vld_out    = s3_v_q;
    assign bus.v_out      = s3_lanes_q;
    assign bus.pos_clamp  = s3_pos_q;
    assign bus.kv_counter = kv_q;
    assign bus.tile_last  = (kv_q == KW'(SEQ_LEN - 1));

    // Stage 1 capture: raw score, running max, bypass flag and lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_byp_q   <= 1'b0;
            s1_lanes_q <= '0;
        end else if (s1_ld) begin
            s1_v_q <= bus.vld_in;
            if (bus.vld_in) begin
                s1_a_q     <= bus.a_in;
                s1_b_q     <= bus.b_in;
                s1_byp_q   <= bus.bypass;
                s1_lanes_q <= bus.v_in;
            end
        end
    end

    // Shift amount: t = 1.4375*x, L = floor(0.5 - t) in 1/16 units, clamped to [0, LMAX].
    always_comb begin
        x     = {s1_a_q[7], s1_a_q} - {s1_b_q[7], s1_b_q};
        xw    = q_convert(x);
        t     = xw + (xw >>> 1) - (xw >>> 4);
        n     = 11'sd8 - {t[9], t};
        lr    = n[10:4];
        l_d   = '0;
        if (n >= 11'sd16) begin
            if (32'(lr) > LMAX) l_d = LW'(LMAX);
            else                l_d = LW'(lr);
        end
        pos_d = (x > 9'sd0);
    end

    // Stage 2 capture: shift amount, bypass, clamp flag and lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q     <= 1'b0;
            s2_l_q     <= '0;
            s2_byp_q   <= 1'b0;
            s2_pos_q   <= 1'b0;
            s2_lanes_q <= '0;
        end else if (s2_ld) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_l_q     <= l_d;
                s2_byp_q   <= s1_byp_q;
                s2_pos_q   <= pos_d;
                s2_lanes_q <= s1_lanes_q;
            end
        end
    end

    assign shamt = s2_byp_q ? '0 : s2_l_q;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        expmul_lane_shift #(
            .W  (LANE_BITS),
            .LW (LW)
        ) u_shift (
            .lane_i  (s2_lanes_q[g*LANE_BITS +: LANE_BITS]),
            .shamt_i (shamt),
            .lane_o  (shifted[g*LANE_BITS +: LANE_BITS])
        );
    end

    // Stage 3 capture: shifted lanes drive v_out and hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v_q     <= 1'b0;
            s3_pos_q   <= 1'b0;
            s3_lanes_q <= '0;
        end else if (s3_ld) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_pos_q   <= s2_pos_q;
                s3_lanes_q <= shifted;
            end
        end
    end

    // KV index advances on every output handshake, wrapping at the tile end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_q <= '0;
        end else if (s3_v_q && bus.rdy_in) begin
            kv_q <= (kv_q == KW'(SEQ_LEN - 1)) ? '0 : kv_q + KW'(1);
        end
    end
endmodule

// File: tb/tb_expmul_pipe.sv
// Scoreboard bench for expmul_pipe: real-arithmetic reference model, queue-based checking.
module tb_expmul_pipe;
    import expmul_pipe_pkg::*;

    localparam int unsigned DIM = 4, VI = 9, VF = 17, SL = 4, LW = 5;
    localparam int unsigned W  = VI + VF;
    localparam int unsigned NL = DIM + 1;
    localparam int unsigned VW = NL * W;

    typedef struct {
        logic [VW-1:0] v;
        logic          pos;
        int            pcyc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    expmul_pipe_if #(.DIM(DIM), .VEC_I(VI), .VEC_F(VF), .SEQ_LEN(SL)) bus ();

    expmul_pipe #(.DIM(DIM), .VEC_I(VI), .VEC_F(VF), .SEQ_LEN(SL), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t          sb[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            exp_kv   = 0;
    int            rdy_mode = 0;
    bit            held     = 0;
    logic [VW-1:0] h_v;
    int            h_kv, h_tl, h_pos;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_i(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: v * 2^-L with L = floor(0.5 - t), t from the exact shifted-sum of x.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic byp,
                                  input logic [VW-1:0] vin,
                                  output logic [VW-1:0] vout, output logic pos);
        int xi, L;
        real t, lr, p, r;
        logic signed [W-1:0] lv;
        xi  = int'($signed(a)) - int'($signed(b));
        pos = (xi > 0);
        t   = (xi + $floor(xi / 2.0) - $floor(xi / 16.0)) / 16.0;
        lr  = $floor(0.5 - t);
        if (byp || lr < 0.0) L = 0;
        else if (lr > 31.0)  L = 31;
        else                 L = $rtoi(lr);
        p = 1.0;
        repeat (L) p = p * 2.0;
        vout = '0;
        for (int i = 0; i < NL; i++) begin
            lv = vin[i*W +: W];
            r  = $floor($itor(lv) / p);
            vout[i*W +: W] = W'($rtoi(r));
        end
    endfunction

    function automatic logic [VW-1:0] mk(input int l0, input int l1, input int l2,
                                         input int l3, input int l4);
        logic [VW-1:0] v;
        int l[5];
        l = '{l0, l1, l2, l3, l4};
        for (int i = 0; i < NL; i++) v[i*W +: W] = W'(l[i]);
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_lanes();
        logic [VW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic byp,
                        input logic [VW-1:0] vin, input bit lat);
        exp_t e;
        logic [VW-1:0] ev;
        logic ep;
        bit done = 0;
        model(a, b, byp, vin, ev, ep);
        @(posedge clk); #1;
        bus.vld_in = 1'b1; bus.a_in = a; bus.b_in = b; bus.bypass = byp; bus.v_in = vin;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.rdy_out) begin
                e.v = ev; e.pos = ep; e.pcyc = cyc; e.chk_lat = lat;
                sb.push_back(e);
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk_i("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.vld_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk_i("drain_pending", sb.size(), 0);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Downstream ready driver.
    initial begin
        bus.rdy_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0)      bus.rdy_in = 1'b1;
            else if (rdy_mode == 1) bus.rdy_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stall stability and scoreboard comparison on every output handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_kv = 0;
            held   = 0;
        end else begin
            if (held) begin
                chk_i("hold_vld", int'(bus.vld_out), 1);
                chk_v("hold_v_out", bus.v_out, h_v);
                chk_i("hold_kv", int'(bus.kv_counter), h_kv);
                chk_i("hold_tile_last", int'(bus.tile_last), h_tl);
                chk_i("hold_pos_clamp", int'(bus.pos_clamp), h_pos);
            end
            if (bus.vld_out && !bus.rdy_in) begin
                held  = 1;
                h_v   = bus.v_out;
                h_kv  = int'(bus.kv_counter);
                h_tl  = int'(bus.tile_last);
                h_pos = int'(bus.pos_clamp);
            end else begin
                held = 0;
            end
            if (bus.vld_out && bus.rdy_in) begin
                if (sb.size() == 0) begin
                    chk_i("unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_v("v_out", bus.v_out, e.v);
                    chk_i("pos_clamp", int'(bus.pos_clamp), int'(e.pos));
                    chk_i("kv_counter", int'(bus.kv_counter), exp_kv);
                    chk_i("tile_last", int'(bus.tile_last), (exp_kv == SL - 1) ? 1 : 0);
                    if (e.chk_lat) chk_i("latency", cyc - e.pcyc, 3);
                    exp_kv = (exp_kv + 1) % SL;
                end
            end
        end
    end

    initial begin
        bus.vld_in = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.bypass = 1'b0; bus.v_in = '0;

        #12;
        chk_i("rst_vld_out", int'(bus.vld_out), 0);
        chk_i("rst_rdy_out", int'(bus.rdy_out), 1);
        chk_i("rst_kv", int'(bus.kv_counter), 0);
        chk_i("rst_tile_last", int'(bus.tile_last), 0);
        chk_i("rst_pos_clamp", int'(bus.pos_clamp), 0);
        chk_v("rst_v_out", bus.v_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed beats with exact latency checks.
        send(8'h00, 8'h00, 1'b0, mk('h20000, 'h20000, 'h20000, 'h20000, 'h20000), 1);
        send(8'h00, 8'h20, 1'b0, mk('h20000, -'h20000, 'h1234, -1, 0), 1);
        send(8'h80, 8'h7F, 1'b0, mk('h20000, -1, 'h1FFFFFF, -'h2000000, 5), 1);
        send(8'h10, 8'h00, 1'b0, mk('h20000, -'h20000, 7, -7, 'h12345), 1);
        send(8'h00, 8'h20, 1'b1, mk('h20000, -'h20000, 'h1234, -1, 3), 1);
        send(8'h7F, 8'h80, 1'b0, mk(-5, 5, 'h1FFFFFF, -'h2000000, 1), 1);
        send(8'h00, 8'h06, 1'b0, mk(-3, 3, 'h20000, -'h20001, 1), 1);
        send(8'h00, 8'h05, 1'b0, mk(-3, 3, 'h20000, -'h20001, 1), 1);
        idle();
        drain();

        // Eight back-to-back beats through a three-cycle downstream stall.
        pulse_rst();
        rdy_mode = 2;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'($urandom), 8'($urandom), 1'b0, rnd_lanes(), 0);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.rdy_in = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.rdy_in = 1'b1;
            end
        join
        drain();

        // Random traffic with random gaps and back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 160; i++) begin
            send(8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), rnd_lanes(), 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rdy_mode = 0;
        drain();

        // Reset with beats in flight: one parked at the output, one behind it.
        if (exp_kv == 0) begin
            send(8'h01, 8'h02, 1'b0, rnd_lanes(), 0);
            idle();
            drain();
        end
        rdy_mode = 2;
        @(posedge clk); #1 bus.rdy_in = 1'b0;
        send(8'h00, 8'h00, 1'b0, rnd_lanes(), 0);
        send(8'h00, 8'h10, 1'b0, rnd_lanes(), 0);
        repeat (3) @(posedge clk);
        chk_i("pre_rst_vld_out", int'(bus.vld_out), 1);
        #2;
        rst = 1'b1;
        bus.vld_in = 1'b0;
        #1;
        chk_i("mid_rst_vld_out", int'(bus.vld_out), 0);
        chk_i("mid_rst_kv", int'(bus.kv_counter), 0);
        chk_i("mid_rst_rdy_out", int'(bus.rdy_out), 1);
        chk_v("mid_rst_v_out", bus.v_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rdy_in = 1'b1;
        rdy_mode = 0;
        send(8'h00, 8'h20, 1'b0, mk('h20000, -'h20000, 8, -8, 0), 1);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
